// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Edges from the load edge until Done is observed high.
  function automatic int latency(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Multiplier control: FSM and step counter.
// Strobes are decoded from state; Idle/Done are registered copies of the state.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          St,
  input  logic          last,
  output logic          load,
  output logic          step,
  output logic          fix,
  output logic          Idle,
  output logic          Done,
  output logic [CW-1:0] cnt
);

  state_t state;

  assign load = (state == S_IDLE) && St;
  assign step = (state == S_RUN);
  assign fix  = (state == S_SIGN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      Idle  <= 1'b1;
      Done  <= 1'b0;
    end else begin
      Idle <= (state == S_IDLE);
      Done <= (state == S_DONE);
      case (state)
        S_IDLE: if (St) begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (last) state <= S_SIGN;
          else      cnt   <= cnt + 1'b1;
        end
        S_SIGN: state <= S_DONE;
        S_DONE: if (!St) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH shift-add multiplier, unsigned or signed per operation.
// Signed operands are multiplied as magnitudes and the product negated once at the end.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 St,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
  output logic                 Idle,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CW = $clog2(WIDTH);

  logic             load, step, fix, last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag_cand, a_mag, b_mag, addend;
  logic [WIDTH:0]   sum;
  logic             neg;

  mult_ctrl #(.WIDTH(WIDTH), .CW(CW)) u_ctrl (
    .Clk   (Clk),
    .Reset (Reset),
    .St    (St),
    .last  (last),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .Idle  (Idle),
    .Done  (Done),
    .cnt   (cnt)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    a_mag  = (Signed && Mcand[WIDTH-1])  ? -Mcand  : Mcand;
    b_mag  = (Signed && Mplier[WIDTH-1]) ? -Mplier : Mplier;
    addend = Product[0] ? mag_cand : '0;
    sum    = {1'b0, Product[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Product  <= '0;
      mag_cand <= '0;
      neg      <= 1'b0;
    end else if (load) begin
      Product  <= {{WIDTH{1'b0}}, b_mag};
      mag_cand <= a_mag;
      neg      <= Signed & (Mcand[WIDTH-1] ^ Mplier[WIDTH-1]);
    end else if (step) begin
      // Carry out of the add lands in the top bit after the shift.
      Product <= {sum, Product[WIDTH-1:1]};
    end else if (fix && neg) begin
      Product <= -Product;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;
  import mult_pkg::*;

  logic        clk, rst;
  logic        st8, sg8, idle8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        st4, sg4, idle4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  int n_chk  = 0;
  int n_pass = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .St(st8), .Signed(sg8), .Mcand(a8), .Mplier(b8),
    .Idle(idle8), .Done(done8), .Product(prod8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(rst), .St(st4), .Signed(sg4), .Mcand(a4), .Mplier(b4),
    .Idle(idle4), .Done(done4), .Product(prod4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One W=8 operation; hold>0 keeps St high through DONE for that many edges.
  task automatic op8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input int hold, input bit toggle);
    int  n;
    bit  idle_bad, done_bad;
    @(negedge clk); st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
    @(posedge clk);
    n = 0; idle_bad = 0; done_bad = 0;
    @(negedge clk); if (hold == 0) st8 = 1'b0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (idle8) idle_bad = 1;
      if (toggle) begin a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom); end
    end while (!done8 && n < 40);
    chk({tag, " latency"}, n, latency(8));
    chk({tag, " idle_low"}, idle_bad, 0);
    chk({tag, " product"}, prod8, exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        if (!done8 || prod8 !== exp) done_bad = 1;
      end
      chk({tag, " done_held"}, done_bad, 0);
      st8 = 1'b0;
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({tag, " back_idle"}, {idle8, done8}, 2'b10);
  endtask

  task automatic op4(input string tag, input logic s, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp);
    int n;
    @(negedge clk); st4 = 1'b1; sg4 = s; a4 = a; b4 = b;
    @(posedge clk); n = 0;
    @(negedge clk); st4 = 1'b0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done4 && n < 40);
    chk({tag, " latency"}, n, latency(4));
    chk({tag, " product"}, prod4, exp);
    @(posedge clk); @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    st8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    st4 = 0; sg4 = 0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset w8", {idle8, done8, prod8}, {1'b1, 1'b0, 16'h0000});
    chk("reset w4", {idle4, done4, prod4}, {1'b1, 1'b0, 8'h00});
    rst = 1'b0;

    op8("u 13x11",   1'b0, 8'd13,  8'd11,  16'h008F, 0, 0);
    op8("u 255x255", 1'b0, 8'd255, 8'd255, 16'hFE01, 0, 0);
    op8("s -3x5",    1'b1, 8'hFD,  8'd5,   16'hFFF1, 0, 0);
    op8("s -128x-128", 1'b1, 8'h80, 8'h80, 16'h4000, 0, 0);
    op8("s 127x-128",  1'b1, 8'h7F, 8'h80, 16'hC080, 0, 0);
    op8("s -1x0",    1'b1, 8'hFF,  8'h00,  16'h0000, 0, 0);

    // Reset on the fourth RUN edge discards the operation.
    @(negedge clk); st8 = 1'b1; sg8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk);
    @(negedge clk); st8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("mid-run reset", {idle8, done8, prod8}, {1'b1, 1'b0, 16'h0000});
    op8("after reset 7x6", 1'b0, 8'd7, 8'd6, 16'h002A, 0, 0);

    op8("hold 5x5",    1'b0, 8'd5, 8'd5, 16'h0019, 5, 0);
    op8("toggle 2x3",  1'b0, 8'd2, 8'd3, 16'h0006, 0, 1);

    op4("w4 u 15x15", 1'b0, 4'd15, 4'd15, 8'hE1);
    op4("w4 s -8x7",  1'b1, 4'h8,  4'd7,  8'hC8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
